// File: rtl/instr_fetch_queue.sv
// Circular instruction FIFO with a registered issue stage feeding the control unit.
// Optional FETCH_Q_OPCODE_CHECK_EN squashes undefined opcodes (101/110/111) to NOP.
module instr_fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [INSTR_W-1:0]           in_instr,
   output logic                         in_ready,
   input  logic                         stall,
   input  logic                         flush,
   output logic [2:0]                   opcode,
   output logic                         valid,
   output logic [INSTR_W-4:0]           operand,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         illegal_op
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_e;

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]      wptr_q, wptr_d;
   logic [PW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      count_q, count_d;
   state_e             state_q, state_d;
   logic [2:0]         opc_q, opc_d;
   logic [INSTR_W-4:0] opr_q, opr_d;
   logic               ill_q, ill_d;
   logic               push, pop, bad;
   logic [INSTR_W-1:0] head;

   assign in_ready = (count_q < CW'(DEPTH)) && !flush;
   assign push     = in_valid && in_ready;
   assign pop      = (count_q != '0) && ((state_q == S_EMPTY) || !stall) && !flush;
   assign head     = mem_q[rptr_q];

`ifdef FETCH_Q_OPCODE_CHECK_EN
   assign bad = (head[INSTR_W-1 -: 3] > 3'd4);
`else
   assign bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= in_instr;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      opr_d   = opr_q;
      ill_d   = 1'b0;
      if (flush) begin
         state_d = S_EMPTY;
         opc_d   = 3'b000;
         opr_d   = '0;
      end else if (pop) begin
         state_d = S_FULL;
         opc_d   = bad ? 3'b000 : head[INSTR_W-1 -: 3];
         opr_d   = bad ? '0 : head[INSTR_W-4:0];
         ill_d   = bad;
      end else if ((state_q == S_FULL) && !stall) begin
         // Drained with nothing behind it: present a NOP bubble.
         state_d = S_EMPTY;
         opc_d   = 3'b000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= S_EMPTY;
         opc_q   <= 3'b000;
         opr_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         state_q <= state_d;
         opc_q   <= opc_d;
         opr_q   <= opr_d;
         ill_q   <= ill_d;
      end
   end

   assign opcode     = opc_q;
   assign operand    = opr_q;
   assign valid      = (state_q == S_FULL);
   assign count      = count_q;
   assign illegal_op = ill_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, INSTR_W=16): vector table
// plus hand sequences for wrap, flush, opcode check and mid-run reset.
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        stall;
   logic        flush;
   logic [2:0]  opcode;
   logic        valid;
   logic [12:0] operand;
   logic [2:0]  count;
   logic        illegal_op;

   int n_tests = 0;
   int n_fail  = 0;

   instr_fetch_queue #(.DEPTH(4), .INSTR_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_ready   (in_ready),
      .stall      (stall),
      .flush      (flush),
      .opcode     (opcode),
      .valid      (valid),
      .operand    (operand),
      .count      (count),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] ins;
      logic        st;
      logic        rdy;
      logic        vld;
      logic [2:0]  opc;
      logic [12:0] opr;
      logic        chk_opr;
      logic [2:0]  cnt;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] wword(input int i);
      logic [2:0]  op;
      logic [12:0] lo;
      op = 3'(i % 5);
      lo = 13'(i + 'h100);
      return {op, lo};
   endfunction

   initial begin
      logic [15:0] w;

      tbl[0]  = '{1'b1, 16'h0011, 1'b1, 1'b1, 1'b0, 3'd0, 13'h0000, 1'b1, 3'd1};
      tbl[1]  = '{1'b1, 16'h2022, 1'b1, 1'b1, 1'b1, 3'd0, 13'h0011, 1'b1, 3'd1};
      tbl[2]  = '{1'b1, 16'h4033, 1'b1, 1'b1, 1'b1, 3'd0, 13'h0011, 1'b1, 3'd2};
      tbl[3]  = '{1'b1, 16'h6044, 1'b1, 1'b1, 1'b1, 3'd0, 13'h0011, 1'b1, 3'd3};
      tbl[4]  = '{1'b1, 16'h8055, 1'b1, 1'b1, 1'b1, 3'd0, 13'h0011, 1'b1, 3'd4};
      tbl[5]  = '{1'b1, 16'h0077, 1'b1, 1'b0, 1'b1, 3'd0, 13'h0011, 1'b1, 3'd4};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, 13'h0022, 1'b1, 3'd3};
      tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd2, 13'h0033, 1'b1, 3'd2};
      tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd3, 13'h0044, 1'b1, 3'd1};
      tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd4, 13'h0055, 1'b1, 3'd0};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd0};
      tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd0};
      tbl[12] = '{1'b1, 16'h2ABC, 1'b0, 1'b1, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd1};
      tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd1, 13'h0ABC, 1'b1, 3'd0};
      tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd0};
      tbl[15] = '{1'b1, 16'h4111, 1'b1, 1'b1, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd1};
      tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd2, 13'h0111, 1'b1, 3'd0};
      tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd2, 13'h0111, 1'b1, 3'd0};
      tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd0};

      // Reset
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_valid",   32'(valid),      32'd0);
      chk("rst_opcode",  32'(opcode),     32'd0);
      chk("rst_operand", 32'(operand),    32'd0);
      chk("rst_count",   32'(count),      32'd0);
      chk("rst_ready",   32'(in_ready),   32'd1);
      chk("rst_illegal", 32'(illegal_op), 32'd0);

      // Vector table: fill under stall, drain, single push, stall on bubble
      for (int i = 0; i < 19; i++) begin
         in_valid = tbl[i].iv;
         in_instr = tbl[i].ins;
         stall    = tbl[i].st;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         tick();
         chk($sformatf("v%0d_valid", i), 32'(valid), 32'(tbl[i].vld));
         chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(tbl[i].opc));
         if (tbl[i].chk_opr)
            chk($sformatf("v%0d_operand", i), 32'(operand), 32'(tbl[i].opr));
         chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("v%0d_illegal", i), 32'(illegal_op), 32'd0);
      end

      // Pointer wrap: 10-word stream, no stall
      stall = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_instr = wword(i);
         tick();
         chk($sformatf("wrap%0d_count", i), 32'(count), 32'd1);
         chk($sformatf("wrap%0d_valid", i), 32'(valid), 32'(i > 0));
         if (i > 0) begin
            w = wword(i - 1);
            chk($sformatf("wrap%0d_word", i), 32'({opcode, operand}), 32'(w));
         end
      end
      in_valid = 1'b0;
      tick();
      w = wword(9);
      chk("wrap_last_word",  32'({opcode, operand}), 32'(w));
      chk("wrap_last_count", 32'(count), 32'd0);
      tick();
      chk("wrap_idle_valid", 32'(valid), 32'd0);

      // Flush with 3 buffered, output valid, push offered
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_instr = 16'h2100 + 16'(i);
         tick();
      end
      chk("fl_pre_count", 32'(count), 32'd3);
      chk("fl_pre_valid", 32'(valid), 32'd1);
      flush    = 1'b1;
      in_instr = 16'h6EEE;
      #1;
      chk("fl_ready", 32'(in_ready), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      stall    = 1'b0;
      chk("fl_count",   32'(count),   32'd0);
      chk("fl_valid",   32'(valid),   32'd0);
      chk("fl_opcode",  32'(opcode),  32'd0);
      chk("fl_operand", 32'(operand), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("fl_after%0d_valid", i), 32'(valid), 32'd0);
         chk($sformatf("fl_after%0d_count", i), 32'(count), 32'd0);
      end

      // Undefined opcode 110
      in_valid = 1'b1;
      in_instr = 16'hC123;
      tick();
      in_valid = 1'b0;
      tick();
      chk("ill_valid", 32'(valid), 32'd1);
`ifdef FETCH_Q_OPCODE_CHECK_EN
      chk("ill_opcode",  32'(opcode),     32'd0);
      chk("ill_operand", 32'(operand),    32'd0);
      chk("ill_flag",    32'(illegal_op), 32'd1);
`else
      chk("ill_opcode",  32'(opcode),     32'd6);
      chk("ill_operand", 32'(operand),    32'h0123);
      chk("ill_flag",    32'(illegal_op), 32'd0);
`endif
      tick();
      chk("ill_next_valid", 32'(valid),      32'd0);
      chk("ill_next_flag",  32'(illegal_op), 32'd0);

      // Asynchronous reset mid-operation
      stall    = 1'b1;
      in_valid = 1'b1;
      in_instr = 16'h2001;
      tick();
      in_instr = 16'h2002;
      tick();
      chk("ar_pre_valid", 32'(valid), 32'd1);
      chk("ar_pre_count", 32'(count), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(valid), 32'd0);
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      stall    = 1'b0;
      in_instr = 16'h4222;
      tick();
      chk("ar_push_count", 32'(count), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("ar_out_valid",  32'(valid),   32'd1);
      chk("ar_out_opcode", 32'(opcode),  32'd2);
      chk("ar_out_oper",   32'(operand), 32'h0222);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
